rom_access_arbiter: RTL

//  Shares the single combinational instruction ROM between the fetch stage (IF) and the data-load path (D).

---
 rtl/rom_access_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/rom_access_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM. Fetch (IF) and
// data-load (D) requests share one ROM read with a fixed 2-cycle response latency.
module rom_access_arbiter #(
    parameter int INDEX_BITS     = 9,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    state_t              state;
    state_t              state_next;
    logic [STREAK_W-1:0] streak;
    logic                win_if;
    logic                grant_window;
    logic                if_wins;
    logic                access_err;

    // rom_address doubles as the latched grant address, so the error check runs on it.
    assign access_err = rom_address[0] | (|rom_address[31:INDEX_BITS+1]);

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_window = 1'b0;
        if_wins      = 1'b0;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        state_next   = state;
        busy         = (state != IDLE);

        grant_window = !reset && (state == IDLE || state == RESP);
        if_wins      = if_req && (!d_req || streak == STREAK_MAX);
        if_gnt       = grant_window && if_wins;
        d_gnt        = grant_window && d_req && !if_wins;

        case (state)
            IDLE:    if (if_gnt || d_gnt) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = (if_gnt || d_gnt) ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            streak      <= '0;
            win_if      <= 1'b0;
            rom_address <= '0;
            if_rvalid   <= 1'b0;
            if_rdata    <= '0;
            if_err      <= 1'b0;
            d_rvalid    <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
        end else begin
            state <= state_next;

            if (if_gnt || d_gnt) begin
                win_if      <= if_gnt;
                rom_address <= if_gnt ? if_addr : d_addr;
            end

            // Streak counts D grants that made a waiting IF request wait longer.
            if (!if_req || if_gnt) begin
                streak <= '0;
            end else if (d_gnt && streak < STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
            end

            if_rvalid <= (state == ACCESS) && win_if;
            d_rvalid  <= (state == ACCESS) && !win_if;
            if_err    <= (state == ACCESS) && win_if && access_err;
            d_err     <= (state == ACCESS) && !win_if && access_err;

            if (state == ACCESS) begin
                if (win_if) begin
                    if_rdata <= access_err ? 32'h0 : rom_data;
                end else begin
                    d_rdata  <= access_err ? 32'h0 : rom_data;
                end
            end
        end
    end

endmodule
